// File: rtl/emul_demux_sm_core.sv
// emul_demux_sm_core
// Datapath engine of the emul_demux_SM IP. It routes an input sample stream
// to one of four output channels. The channel is either fixed (fix_sel) or
// chosen round-robin over the enabled channels (ch_mask), moving on after a
// programmable number of samples (dwell).
//
// Optional feature macro: EMUL_DEMUX_CNT_EN
//   defined   : cnt0..cnt3 count accepted output beats per channel
//   undefined : counter logic removed, cnt0..cnt3 tied to 0
//
// Ports
//   ACLK, ARESETN      clock, asynchronous active-low reset
//   ctrl               bit0 enable, bit1 counter clear (level), bit2 mode (1 = round-robin)
//   fix_sel[1:0]       channel used in fixed mode
//   dwell[15:0]        samples per channel in round-robin (0 behaves as 1)
//   ch_mask[3:0]       channel enable mask
//   s_valid/s_ready/s_data        input stream
//   m_valid/m_ready/m_data        one-hot output valid, per-channel ready, shared data
//   cur_ch             currently selected channel
//   busy               high in SEEK or RUN
//   cnt0..cnt3         per-channel accepted-beat counters
//   o_dbg_state        FSM state (0 IDLE, 1 SEEK, 2 RUN)
//
// Handshake: a beat moves on any interface in a cycle where valid and ready
// are both high at the rising clock edge; valid never waits for ready, and
// m_valid/m_data stay stable while a beat is offered and not taken.
module emul_demux_sm_core #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [31:0]           ctrl,
    input  logic [31:0]           fix_sel,
    input  logic [31:0]           dwell,
    input  logic [31:0]           ch_mask,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [NUM_CH-1:0]     m_valid,
    input  logic [NUM_CH-1:0]     m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            cur_ch,
    output logic                  busy,
    output logic [31:0]           cnt0,
    output logic [31:0]           cnt1,
    output logic [31:0]           cnt2,
    output logic [31:0]           cnt3,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_cur_ch;
    logic [15:0]           r_dwell_cnt;
    logic [NUM_CH-1:0]     r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;

    logic                  w_s_ready;
    logic                  w_acc;
    logic                  w_pop;
    logic                  w_out_free;
    logic                  w_seek_ok;
    logic [1:0]            w_low_ch;
    logic [1:0]            w_next_ch;
    logic [1:0]            w_cand;
    logic                  w_found;
    logic [15:0]           w_dwell_last;

    // The holding register may belong to the previous channel after a
    // switch, so draining is judged on whichever channel it targets.
    assign w_pop      = |(r_m_valid & m_ready);
    assign w_out_free = ~(|r_m_valid) | w_pop;
    assign w_acc      = s_valid & w_s_ready;

    assign w_dwell_last = (dwell[15:0] == 16'd0) ? 16'd0 : dwell[15:0] - 16'd1;

    always_comb begin
        w_low_ch = 2'd3;
        if (ch_mask[0])      w_low_ch = 2'd0;
        else if (ch_mask[1]) w_low_ch = 2'd1;
        else if (ch_mask[2]) w_low_ch = 2'd2;
    end

    // Next enabled channel above the current one, wrapping 3 -> 0. With no
    // other bit set the current channel is kept.
    always_comb begin
        w_next_ch = r_cur_ch;
        w_found   = 1'b0;
        w_cand    = 2'd0;
        for (int i = 1; i < 4; i++) begin
            w_cand = r_cur_ch + 2'(i);
            if (!w_found && ch_mask[w_cand]) begin
                w_next_ch = w_cand;
                w_found   = 1'b1;
            end
        end
    end

    assign w_seek_ok = ctrl[2] ? (|ch_mask[3:0]) : ch_mask[fix_sel[1:0]];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (ctrl[0]) w_state_nxt = SEEK;
            end
            SEEK: begin
                if (!ctrl[0])       w_state_nxt = IDLE;
                else if (w_seek_ok) w_state_nxt = RUN;
            end
            RUN: begin
                // Disable stops intake at once; leave only after the
                // pending beat has been handed over.
                if (ctrl[0])         w_s_ready   = w_out_free;
                else if (w_out_free) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_m_valid   <= '0;
            r_m_data    <= '0;
            r_cur_ch    <= 2'd0;
            r_dwell_cnt <= 16'd0;
        end else begin
            if (w_acc) begin
                r_m_data  <= s_data;
                r_m_valid <= NUM_CH'(1) << r_cur_ch;
            end else if (w_pop) begin
                r_m_valid <= '0;
            end

            if (r_state == SEEK) begin
                r_cur_ch    <= ctrl[2] ? w_low_ch : fix_sel[1:0];
                r_dwell_cnt <= 16'd0;
            end else if (w_acc && ctrl[2]) begin
                // The beat accepted on the last dwell slot still goes to the
                // old channel; the switch applies from the next beat.
                if (r_dwell_cnt >= w_dwell_last) begin
                    r_cur_ch    <= w_next_ch;
                    r_dwell_cnt <= 16'd0;
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + 16'd1;
                end
            end
        end
    end

`ifdef EMUL_DEMUX_CNT_EN
    logic [31:0] r_cnt [4];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ctrl[1])                        r_cnt[i] <= 32'd0;
                else if (r_m_valid[i] && m_ready[i]) r_cnt[i] <= r_cnt[i] + 32'd1;
            end
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
    assign cnt3 = r_cnt[3];

    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, ctrl[31:3], fix_sel[31:2], dwell[31:16], ch_mask[31:4]};
`else
    assign cnt0 = 32'd0;
    assign cnt1 = 32'd0;
    assign cnt2 = 32'd0;
    assign cnt3 = 32'd0;

    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, ctrl[31:3], ctrl[1], fix_sel[31:2], dwell[31:16], ch_mask[31:4]};
`endif

    assign s_ready     = w_s_ready;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign cur_ch      = r_cur_ch;
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule
